div_unit: RTL and testbench

//  Iterative RV32M divide unit: DIV, DIVU, REM, REMU.

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring,
//            one quotient bit per clock with a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             is_rem_q;

  // Operand decode at start
  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH-1:0] special_res;

  assign is_signed   = ~op[0];
  assign dvd_neg     = is_signed & dividend[WIDTH-1];
  assign dvs_neg     = is_signed & divisor[WIDTH-1];
  assign dvd_abs     = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_abs     = dvs_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero    = (divisor == '0);
  assign overflow    = is_signed & (dividend == C_MIN) & (divisor == '1);
  assign special     = div_zero | overflow;
  assign special_res = div_zero ? (op[1] ? dividend : '1)
                                : (op[1] ? '0 : C_MIN);

  // One restoring step; the extra top bit exposes the trial-subtract borrow
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_q};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_nx  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], q_bit};
  assign quo_fin = neg_q_q ? (~quo_nx + 1'b1) : quo_nx;
  assign rem_fin = neg_r_q ? (~rem_nx[WIDTH-1:0] + 1'b1) : rem_nx[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_rem_q <= op[1];
            neg_q_q  <= dvd_neg ^ dvs_neg;
            neg_r_q  <= dvd_neg;
            if (special) begin
              result <= special_res;
            end else begin
              dvs_q <= dvs_abs;
              quo_q <= dvd_abs;
              rem_q <= '0;
              cnt_q <= '0;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            result <= is_rem_q ? rem_fin : quo_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V semantics expressed with plain arithmetic
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = $signed(a);
      sb = $signed(b);
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    int exp_lat;
    logic busy_seen;
    exp_lat = ref_latency(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done) busy_seen = busy_seen | busy;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, ref_model(o, a, b));
    check({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, exp_lat > 1});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, ref_model(o, a, b));
  endtask

  initial begin
    int ndone;
    int done_edge;
    logic [31:0] done_res;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_min_1", 2'b00, 32'h8000_0000, 32'd1);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op("div_0_m0", 2'b00, 32'hFFFF_FFF0, 32'd0);

    // start during CALC must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_edge = -1; done_res = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        done_edge = k;
        done_res = result;
      end
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_edge", 32'(done_edge), 32'd32);
    check("ign_res", done_res, 32'd14);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_nodone", 32'(ndone), 32'd0);
    run_op("after_rst", 2'b01, 32'd9, 32'd3);

    // randomized mix including the special cases
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else rb = $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
